ram_1rw_nr_clr: RTL and testbench

Parametrised successor to the single-write/single-read 64-bit byte-enabled register-file RAM. It provides one read/write port (port 0) and NRD independent read-only ports, with these additions:
- configurable data width and depth;
- selectable read-during-write semantics;
- an optional output pipeline register;
- per-port read-valid strobes;
- a hardware clear sequencer that zeroes the array after reset.

It is used for the core's GPR/SPR files and small caches in ASIC flows, where SRAM macros have no defined power-up contents.

---
 rtl/ram_1rw_nr_clr.sv | 132 +++++++++++++
 tb/tb_ram_1rw_nr_clr.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1rw_nr_clr.sv
// Byte-enabled register-file RAM: one read/write port plus NRD read-only ports,
// selectable read-during-write behaviour, optional output stage and post-reset clear.
module ram_1rw_nr_clr #(
  parameter int BITS           = 5,
  parameter int WIDTH          = 64,
  parameter int NRD            = 2,
  parameter int WRITE_FIRST    = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  output logic                 BUSY,
  input  logic                 EN0,
  input  logic [BITS-1:0]      A0,
  input  logic [WIDTH/8-1:0]   WE0,
  input  logic [WIDTH-1:0]     Di0,
  output logic [WIDTH-1:0]     Do0,
  output logic                 VLD0,
  input  logic [NRD-1:0]       EN1,
  input  logic [NRD*BITS-1:0]  A1,
  output logic [NRD*WIDTH-1:0] Do1,
  output logic [NRD-1:0]       VLD1
);
  localparam int NB = WIDTH / 8;
  localparam int NP = NRD + 1;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t           r_state;
  logic [BITS-1:0]  r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] r_mem [2**BITS];

  logic             w_acc;
  logic             w_wr;
  logic [WIDTH-1:0] w_old0;
  logic [WIDTH-1:0] w_merged;
  logic [NP-1:0]    w_en;
  logic [BITS-1:0]  w_addr [NP];
  logic [WIDTH-1:0] w_rd   [NP];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      r_busy  <= (CLEAR_ON_RESET != 0);
      r_cnt   <= '0;
    end else if (r_state == S_CLEAR) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == '1) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

  assign BUSY   = r_busy;
  assign w_acc  = ~r_busy;
  assign w_wr   = w_acc & EN0;
  assign w_old0 = r_mem[A0];

  always_comb begin
    w_merged = w_old0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (WE0[i]) w_merged[i*8 +: 8] = Di0[i*8 +: 8];
    end
  end

  // Memory has no reset; the clear sequencer owns the write port while busy.
  always_ff @(posedge CLK) begin
    if (r_busy) r_mem[r_cnt] <= '0;
    else if (w_wr) r_mem[A0] <= w_merged;
  end

  // Port 0 and the read-only ports are folded into index 0..NRD.
  assign w_en[0]   = EN0;
  assign w_addr[0] = A0;
  for (genvar k = 0; k < NRD; k++) begin : g_map
    assign w_en[k+1]   = EN1[k];
    assign w_addr[k+1] = A1[k*BITS +: BITS];
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    logic             w_hit;
    logic             w_req;
    logic [WIDTH-1:0] r_d;
    logic             r_v;
    logic [WIDTH-1:0] w_do;
    logic             w_vld;

    assign w_hit    = (WRITE_FIRST != 0) && w_wr && (w_addr[p] == A0);
    assign w_rd[p]  = w_hit ? w_merged : r_mem[w_addr[p]];
    assign w_req    = w_acc & w_en[p];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_d <= '0;
        r_v <= 1'b0;
      end else begin
        r_v <= w_req;
        if (w_req) r_d <= w_rd[p];
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] r_q;
      logic             r_qv;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_q  <= '0;
          r_qv <= 1'b0;
        end else begin
          r_qv <= r_v;
          if (r_v) r_q <= r_d;
        end
      end
      assign w_do  = r_q;
      assign w_vld = r_qv;
    end else begin : g_noreg
      assign w_do  = r_d;
      assign w_vld = r_v;
    end

    if (p == 0) begin : g_p0
      assign Do0  = w_do;
      assign VLD0 = w_vld;
    end else begin : g_pk
      assign Do1[(p-1)*WIDTH +: WIDTH] = w_do;
      assign VLD1[p-1]                 = w_vld;
    end
  end
endmodule

// File: tb/tb_ram_1rw_nr_clr.sv
// Two instances share stimulus: A = read-first/no output stage, B = write-first/output stage.
module tb_ram_1rw_nr_clr;
  logic        CLK   = 1'b0;
  logic        RST_N = 1'b1;
  logic        EN0   = 1'b0;
  logic [4:0]  A0    = '0;
  logic [7:0]  WE0   = '0;
  logic [63:0] Di0   = '0;
  logic [1:0]  EN1   = '0;
  logic [9:0]  A1    = '0;

  logic        busy_a, busy_b, vld0_a, vld0_b;
  logic [63:0] do0_a, do0_b;
  logic [127:0] do1_a, do1_b;
  logic [1:0]  vld1_a, vld1_b;

  ram_1rw_nr_clr u_a (
    .CLK(CLK), .RST_N(RST_N), .BUSY(busy_a), .EN0(EN0), .A0(A0), .WE0(WE0), .Di0(Di0),
    .Do0(do0_a), .VLD0(vld0_a), .EN1(EN1), .A1(A1), .Do1(do1_a), .VLD1(vld1_a)
  );

  ram_1rw_nr_clr #(.WRITE_FIRST(1), .OUT_REG(1)) u_b (
    .CLK(CLK), .RST_N(RST_N), .BUSY(busy_b), .EN0(EN0), .A0(A0), .WE0(WE0), .Di0(Di0),
    .Do0(do0_b), .VLD0(vld0_b), .EN1(EN1), .A1(A1), .Do1(do1_b), .VLD1(vld1_b)
  );

  always #5 CLK = ~CLK;

  logic [63:0] ga_d [3];
  logic [63:0] gb_d [3];
  logic        ga_v [3];
  logic        gb_v [3];
  always_comb begin
    ga_d[0] = do0_a; ga_d[1] = do1_a[63:0]; ga_d[2] = do1_a[127:64];
    gb_d[0] = do0_b; gb_d[1] = do1_b[63:0]; gb_d[2] = do1_b[127:64];
    ga_v[0] = vld0_a; ga_v[1] = vld1_a[0]; ga_v[2] = vld1_a[1];
    gb_v[0] = vld0_b; gb_v[1] = vld1_b[0]; gb_v[2] = vld1_b[1];
  end

  // Reference model: array contents, remaining clear cycles, expected outputs.
  logic [63:0] mem_m [32];
  int          busy_left;
  logic [63:0] ea_d [3];
  logic [63:0] eb_d [3];
  logic [63:0] pb_d [3];
  logic        ea_v [3];
  logic        eb_v [3];
  logic        pb_v [3];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [4:0] addr_of(input int p);
    if (p == 0) return A0;
    return A1[(p-1)*5 +: 5];
  endfunction

  function automatic logic en_of(input int p);
    if (p == 0) return EN0;
    return EN1[p-1];
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      ea_d[p] = '0; eb_d[p] = '0; pb_d[p] = '0;
      ea_v[p] = 1'b0; eb_v[p] = 1'b0; pb_v[p] = 1'b0;
    end
    busy_left = 32;
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUTs.
  task automatic step();
    logic [63:0] merged;
    logic [63:0] wf;
    logic        acc, wr, req;
    logic [4:0]  ad;
    acc = (busy_left == 0);
    wr  = acc && EN0;
    merged = mem_m[A0];
    for (int i = 0; i < 8; i++) if (WE0[i]) merged[i*8 +: 8] = Di0[i*8 +: 8];
    for (int p = 0; p < 3; p++) begin
      ad  = addr_of(p);
      req = acc && en_of(p);
      wf  = (wr && ad == A0) ? merged : mem_m[ad];
      ea_v[p] = req;
      if (req) ea_d[p] = mem_m[ad];
      eb_v[p] = pb_v[p];
      if (pb_v[p]) eb_d[p] = pb_d[p];
      pb_v[p] = req;
      if (req) pb_d[p] = wf;
    end
    if (wr) mem_m[A0] = merged;
    if (busy_left > 0) begin
      mem_m[32 - busy_left] = '0;
      busy_left--;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    EN0 = 1'b0; WE0 = '0; EN1 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    #2 RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({busy_a, busy_b} !== 2'b11 || {do0_a, do1_a, vld0_a, vld1_a} !== '0 ||
        {do0_b, do1_b, vld0_b, vld1_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b%b vld=%b%b%b%b do0a=%h do0b=%h, want busy=11 all zero",
               busy_a, busy_b, vld0_a, vld1_a, vld0_b, vld1_b, do0_a, do0_b);
    end
    @(posedge CLK); @(posedge CLK); #1;
    RST_N = 1'b1;
    // Requests during the clear must be ignored, including this write to entry 5.
    EN0 = 1'b1; WE0 = 8'hFF; A0 = 5'd5; Di0 = {$urandom, $urandom};
    EN1 = 2'b11; A1 = {5'd5, 5'd5};
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if ({busy_a, busy_b} !== 2'b11 || {vld0_a, vld1_a, vld0_b, vld1_b} !== '0) begin
        n_bad++;
        $display("FAIL clear_busy cyc %0d: busy=%b%b vld=%b%b%b%b, want busy=11 vld=0",
                 i, busy_a, busy_b, vld0_a, vld1_a, vld0_b, vld1_b);
      end
      step();
    end
    idle_inputs();
    n_cmp++;
    if ({busy_a, busy_b} !== 2'b00) begin
      n_bad++;
      $display("FAIL clear_done: busy=%b%b, want 00", busy_a, busy_b);
    end
  endtask

  task automatic test_clear_readback();
    for (int e = 0; e < 34; e++) begin
      if (e < 32) begin
        EN0 = 1'b1; WE0 = '0; A0 = 5'(e);
        EN1 = 2'b11; A1 = {5'(31 - e), 5'(e)};
      end else idle_inputs();
      step();
      if (e < 32) begin
        n_cmp++;
        if (ga_v[1] !== 1'b1 || ga_d[1] !== 64'h0 || ga_v[2] !== 1'b1 || ga_d[2] !== 64'h0) begin
          n_bad++;
          $display("FAIL clear_read entry %0d: vld=%b%b do=%h/%h, want vld=11 do=0",
                   e, ga_v[1], ga_v[2], ga_d[1], ga_d[2]);
        end
      end
      for (int p = 0; p < 3; p++) begin
        n_cmp++;
        if (gb_v[p] !== eb_v[p] || gb_d[p] !== eb_d[p]) begin
          n_bad++;
          $display("FAIL clear_read_b port%0d step %0d: got %b/%h want %b/%h",
                   p, e, gb_v[p], gb_d[p], eb_v[p], eb_d[p]);
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    EN0 = 1'b1; A0 = 5'd3; WE0 = 8'hFF; Di0 = 64'h1122334455667788; EN1 = '0;
    step();
    WE0 = 8'h0F; Di0 = 64'hAAAA_AAAA_AAAA_AAAA;
    step();
    n_cmp++;
    if (ga_d[0] !== 64'h1122334455667788 || ga_v[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL be_port0_readfirst: got %b/%h want 1/1122334455667788", ga_v[0], ga_d[0]);
    end
    EN0 = 1'b0; WE0 = '0; EN1 = 2'b01; A1[4:0] = 5'd3;
    step();
    n_cmp++;
    if (ga_d[1] !== 64'h11223344AAAAAAAA || ga_v[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL be_read_a: got %b/%h want 1/11223344aaaaaaaa", ga_v[1], ga_d[1]);
    end
    n_cmp++;
    if (gb_d[0] !== 64'h11223344AAAAAAAA || gb_v[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL be_port0_writefirst: got %b/%h want 1/11223344aaaaaaaa", gb_v[0], gb_d[0]);
    end
    idle_inputs();
    step();
    n_cmp++;
    if (gb_d[1] !== 64'h11223344AAAAAAAA || gb_v[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL be_read_b: got %b/%h want 1/11223344aaaaaaaa", gb_v[1], gb_d[1]);
    end
  endtask

  task automatic test_collision();
    EN0 = 1'b1; A0 = 5'd7; WE0 = 8'hFF; Di0 = 64'h0; EN1 = '0;
    step();
    WE0 = 8'h03; Di0 = 64'hFFFF; EN1 = 2'b11; A1 = {5'd7, 5'd7};
    step();
    for (int p = 0; p < 3; p++) begin
      n_cmp++;
      if (ga_d[p] !== 64'h0 || ga_v[p] !== 1'b1) begin
        n_bad++;
        $display("FAIL coll_readfirst port%0d: got %b/%h want 1/0", p, ga_v[p], ga_d[p]);
      end
    end
    idle_inputs();
    step();
    for (int p = 0; p < 3; p++) begin
      n_cmp++;
      if (gb_d[p] !== 64'hFFFF || gb_v[p] !== 1'b1) begin
        n_bad++;
        $display("FAIL coll_writefirst port%0d: got %b/%h want 1/ffff", p, gb_v[p], gb_d[p]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] vals [4];
    for (int k = 1; k <= 3; k++) begin
      vals[k] = {$urandom, $urandom};
      EN0 = 1'b1; A0 = 5'(k); WE0 = 8'hFF; Di0 = vals[k]; EN1 = '0;
      step();
    end
    idle_inputs();
    step(); step();
    for (int c = 1; c <= 5; c++) begin
      if (c <= 3) begin
        EN0 = 1'b1; WE0 = '0; A0 = 5'(c); EN1 = 2'b11; A1 = {5'(c), 5'(c)};
      end else idle_inputs();
      step();
      for (int p = 0; p < 3; p++) begin
        n_cmp++;
        if (c == 1 && gb_v[p] !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_early port%0d: vld=%b want 0", p, gb_v[p]);
        end else if (c >= 2 && c <= 4 && (gb_v[p] !== 1'b1 || gb_d[p] !== vals[c-1])) begin
          n_bad++;
          $display("FAIL b2b_data port%0d cyc %0d: got %b/%h want 1/%h", p, c, gb_v[p], gb_d[p], vals[c-1]);
        end else if (c == 5 && (gb_v[p] !== 1'b0 || gb_d[p] !== vals[3])) begin
          n_bad++;
          $display("FAIL b2b_hold port%0d: got %b/%h want 0/%h", p, gb_v[p], gb_d[p], vals[3]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      EN0 = 1'($urandom); A0 = 5'($urandom_range(0, 7)); WE0 = 8'($urandom);
      Di0 = {$urandom, $urandom}; EN1 = 2'($urandom);
      A1 = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      step();
      for (int p = 0; p < 3; p++) begin
        n_cmp++;
        if (ga_v[p] !== ea_v[p] || ga_d[p] !== ea_d[p]) begin
          n_bad++;
          $display("FAIL rand_a port%0d cyc %0d: got %b/%h want %b/%h", p, c, ga_v[p], ga_d[p], ea_v[p], ea_d[p]);
        end
        n_cmp++;
        if (gb_v[p] !== eb_v[p] || gb_d[p] !== eb_d[p]) begin
          n_bad++;
          $display("FAIL rand_b port%0d cyc %0d: got %b/%h want %b/%h", p, c, gb_v[p], gb_d[p], eb_v[p], eb_d[p]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    logic [63:0] v;
    v = 64'hDEAD_BEEF_0BAD_F00D;
    EN0 = 1'b1; A0 = 5'd9; WE0 = 8'hFF; Di0 = v; EN1 = '0;
    step();
    WE0 = '0; EN1 = 2'b01; A1[4:0] = 5'd9;
    step();
    n_cmp++;
    if (ga_d[0] !== v || ga_v[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_read: got %b/%h want 1/%h", ga_v[1], ga_d[0], v);
    end
    idle_inputs();
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({do0_a, do1_a, vld0_a, vld1_a} !== '0 || {busy_a, busy_b} !== 2'b11) begin
      n_bad++;
      $display("FAIL async_reset: do0a=%h vld=%b%b busy=%b%b, want 0/00/11", do0_a, vld0_a, vld1_a, busy_a, busy_b);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) step();
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({do0_b, do1_b, vld0_b, vld1_b} !== '0 || {busy_a, busy_b} !== 2'b11) begin
      n_bad++;
      $display("FAIL midclear_reset: do0b=%h vld=%b%b busy=%b%b, want 0/00/11", do0_b, vld0_b, vld1_b, busy_a, busy_b);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if ({busy_a, busy_b} !== 2'b11) begin
        n_bad++;
        $display("FAIL restart_busy cyc %0d: busy=%b%b want 11", i, busy_a, busy_b);
      end
      step();
    end
    n_cmp++;
    if ({busy_a, busy_b} !== 2'b00) begin
      n_bad++;
      $display("FAIL restart_done: busy=%b%b want 00", busy_a, busy_b);
    end
    EN0 = 1'b1; A0 = 5'd9; EN1 = 2'b11; A1 = {5'd10, 5'd9};
    step();
    idle_inputs();
    step();
    for (int p = 0; p < 3; p++) begin
      n_cmp++;
      if (gb_v[p] !== 1'b1 || gb_d[p] !== 64'h0 || ga_d[p] !== 64'h0) begin
        n_bad++;
        $display("FAIL post_restart_read port%0d: got a=%h b=%b/%h want 0 and 1/0", p, ga_d[p], gb_v[p], gb_d[p]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear_readback();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
